// File: rtl/mm_pkg.sv
`default_nettype none
// ============================================================================
// mm_pkg : shared state encoding, register offsets and ap_ctrl bit positions
// Revision: 1.0
// ============================================================================
package mm_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_B = 3'd1,
    S_LOAD_A = 3'd2,
    S_CALC   = 3'd3,
    S_DRAIN  = 3'd4
  } state_t;

  localparam int unsigned ADDR_AP_CTRL = 32'h00;
  localparam int unsigned ADDR_N_REG   = 32'h10;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_DONE_BIT  = 1;
  localparam int CTRL_IDLE_BIT  = 2;
  localparam int CTRL_ERR_BIT   = 3;

endpackage
`default_nettype wire

// File: rtl/mm_dot_product.sv
`default_nettype none
// ============================================================================
// mm_dot_product : DIM-lane masked dot product, wrap-around arithmetic
// Revision: 1.0
// ============================================================================
module mm_dot_product
  import mm_pkg::*;
#(
  parameter int DIM         = 4,
  parameter int pDATA_WIDTH = 32,
  parameter int NW          = $clog2(DIM + 1)
) (
  input  logic [pDATA_WIDTH-1:0] a_vec [DIM],
  input  logic [pDATA_WIDTH-1:0] b_vec [DIM],
  input  logic [NW-1:0]          n,
  output logic [pDATA_WIDTH-1:0] sum
);

  logic [pDATA_WIDTH-1:0] prod [DIM];

  // Lanes at or beyond the active size hold stale storage and must contribute 0.
  for (genvar k = 0; k < DIM; k++) begin : g_lane
    localparam logic [NW-1:0] LANE = NW'(k);
    assign prod[k] = (LANE < n) ? a_vec[k] * b_vec[k] : '0;
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < DIM; k++) begin
      sum = sum + prod[k];
    end
  end

endmodule
`default_nettype wire

// File: rtl/mm_stream_nxn.sv
`default_nettype none
// ============================================================================
// mm_stream_nxn : streaming n x n matrix multiplier, AXI-Lite control, AXIS I/O
// Optional macro MM_TLAST_CHECK_EN enables input tlast checking (ap_ctrl.err).
// Revision: 1.0
// ============================================================================
module mm_stream_nxn
  import mm_pkg::*;
#(
  parameter int DIM         = 4,
  parameter int pDATA_WIDTH = 32,
  parameter int pADDR_WIDTH = 12
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  input  logic                   ss_tvalid,
  output logic                   ss_tready,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   sm_tvalid,
  input  logic                   sm_tready,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast
);

  localparam int NW = $clog2(DIM + 1);
  localparam int IW = (DIM > 1) ? $clog2(DIM) : 1;

  state_t                 state;
  logic [IW-1:0]          row, col;
  logic [NW-1:0]          n_reg, n_m1;
  logic                   ap_start, ap_done, ap_idle, err;
  logic [pDATA_WIDTH-1:0] b_mem [DIM][DIM];
  logic [pDATA_WIDTH-1:0] a_row [DIM];
  logic [pDATA_WIDTH-1:0] b_col [DIM];
  logic [pDATA_WIDTH-1:0] dot, ctrl_word;
  logic wr_en, wr_ctrl, wr_n, rd_acc, rd_ctrl, ss_hs, row_last, col_last, issue;

  assign wr_en    = awvalid && wvalid;
  assign awready  = wr_en;
  assign wready   = wr_en;
  assign wr_ctrl  = wr_en && (awaddr == pADDR_WIDTH'(ADDR_AP_CTRL));
  assign wr_n     = wr_en && (awaddr == pADDR_WIDTH'(ADDR_N_REG));
  assign arready  = !rvalid;
  assign rd_acc   = arvalid && !rvalid;
  assign rd_ctrl  = rd_acc && (araddr == pADDR_WIDTH'(ADDR_AP_CTRL));
  assign ss_tready = (state == S_LOAD_B) || (state == S_LOAD_A);
  assign ss_hs    = ss_tvalid && ss_tready;
  assign n_m1     = n_reg - NW'(1);
  assign row_last = (NW'(row) == n_m1);
  assign col_last = (NW'(col) == n_m1);
  assign issue    = (state == S_CALC) && (!sm_tvalid || sm_tready);

  // Operand storage carries no reset; its content is only meaningful after a load.
  always_ff @(posedge axis_clk) begin
    if (ss_hs) begin
      if (state == S_LOAD_B) b_mem[row][col] <= ss_tdata;
      else                   a_row[col]      <= ss_tdata;
    end
  end

  for (genvar k = 0; k < DIM; k++) begin : g_col
    assign b_col[k] = b_mem[k][col];
  end

  mm_dot_product #(
    .DIM         (DIM),
    .pDATA_WIDTH (pDATA_WIDTH),
    .NW          (NW)
  ) u_dot (
    .a_vec (a_row),
    .b_vec (b_col),
    .n     (n_reg),
    .sum   (dot)
  );

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state     <= S_IDLE;
      row       <= '0;
      col       <= '0;
      n_reg     <= NW'(DIM);
      ap_start  <= 1'b0;
      ap_done   <= 1'b0;
      ap_idle   <= 1'b1;
      sm_tvalid <= 1'b0;
      sm_tdata  <= '0;
      sm_tlast  <= 1'b0;
    end else begin
      if (rd_ctrl) ap_done <= 1'b0;
      if (wr_ctrl && wdata[CTRL_START_BIT] && ap_idle) ap_start <= 1'b1;
      if (wr_n && ap_idle)
        n_reg <= (wdata == '0 || wdata > pDATA_WIDTH'(DIM)) ? NW'(DIM) : wdata[NW-1:0];
      if (sm_tvalid && sm_tready) sm_tvalid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (ap_start) begin
            state    <= S_LOAD_B;
            ap_start <= 1'b0;
            ap_done  <= 1'b0;
            ap_idle  <= 1'b0;
            row      <= '0;
            col      <= '0;
          end
        end
        S_LOAD_B: begin
          if (ss_hs) begin
            if (col_last) begin
              col <= '0;
              if (row_last) begin
                row   <= '0;
                state <= S_LOAD_A;
              end else begin
                row <= row + IW'(1);
              end
            end else begin
              col <= col + IW'(1);
            end
          end
        end
        S_LOAD_A: begin
          if (ss_hs) begin
            if (col_last) begin
              col   <= '0;
              state <= S_CALC;
            end else begin
              col <= col + IW'(1);
            end
          end
        end
        S_CALC: begin
          if (issue) begin
            sm_tvalid <= 1'b1;
            sm_tdata  <= dot;
            sm_tlast  <= row_last && col_last;
            if (col_last) begin
              col <= '0;
              if (row_last) begin
                row   <= '0;
                state <= S_DRAIN;
              end else begin
                row   <= row + IW'(1);
                state <= S_LOAD_A;
              end
            end else begin
              col <= col + IW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (sm_tvalid && sm_tready) begin
            ap_done <= 1'b1;
            ap_idle <= 1'b1;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MM_TLAST_CHECK_EN
  localparam int CW = $clog2(2 * DIM * DIM + 1);
  logic [CW-1:0] in_cnt, last_word;

  assign last_word = CW'(2) * CW'(n_reg) * CW'(n_reg) - CW'(1);

  // Sticky: any input word whose tlast disagrees with "is final word" flags err.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      in_cnt <= '0;
      err    <= 1'b0;
    end else if (state == S_IDLE && ap_start) begin
      in_cnt <= '0;
      err    <= 1'b0;
    end else if (ss_hs) begin
      in_cnt <= in_cnt + CW'(1);
      if (ss_tlast != (in_cnt == last_word)) err <= 1'b1;
    end
  end
`else
  logic unused_tlast;
  assign unused_tlast = ss_tlast;
  assign err = 1'b0;
`endif

  always_comb begin
    ctrl_word                 = '0;
    ctrl_word[CTRL_START_BIT] = ap_start;
    ctrl_word[CTRL_DONE_BIT]  = ap_done;
    ctrl_word[CTRL_IDLE_BIT]  = ap_idle;
    ctrl_word[CTRL_ERR_BIT]   = err;
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else if (rd_acc) begin
      rvalid <= 1'b1;
      if (araddr == pADDR_WIDTH'(ADDR_AP_CTRL))    rdata <= ctrl_word;
      else if (araddr == pADDR_WIDTH'(ADDR_N_REG)) rdata <= pDATA_WIDTH'(n_reg);
      else                                         rdata <= '0;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
    end
  end

endmodule
`default_nettype wire
